// File: rtl/input_debounce_if.sv
// Debouncer signal bundle: raw levels in, debounced levels, edge pulses and
// the sample strobe out. The master side drives raw inputs; the slave side
// is the debouncer itself.
interface input_debounce_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             tick;

  modport master (output in, input out, rise, fall, tick);
  modport slave  (input in, output out, rise, fall, tick);
endinterface

// File: rtl/input_debounce.sv
// Multi-channel button/switch debouncer. Each raw input is synchronized,
// sampled once per RATE cycles, and a new level is accepted only after N
// consecutive agreeing samples. Edge pulses accompany each accepted change.
module input_debounce #(
  parameter int WIDTH       = 13,
  parameter int SYNC_STAGES = 3,
  parameter int RATE        = 125000,
  parameter int N           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input_debounce_if.slave  db
);

  localparam int CNT_W = $clog2(RATE);

  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;
  logic rst_int_n;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_w;

  logic [N-1:0]     hist_q [WIDTH];
  logic [N-1:0]     hist_d [WIDTH];
  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Reset synchronizer: assert immediately, release two clocks later.
  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Reset synchronizer flops, cleared straight from the external reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample its pre-edge
      // neighbour, so the chain shifts by exactly one stage per clock.
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q;

  // Input synchronizer chain: stage 0 takes the raw pins, each later stage
  // takes its predecessor.
  always_comb begin
    sync_d[0] = db.in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Prescaler: count 0..RATE-1 and strobe on the terminal count.
  assign tick_w = (cnt_q == CNT_W'(RATE - 1));
  always_comb begin
    cnt_d = tick_w ? '0 : cnt_q + CNT_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sample on each tick and accept a level once the whole history agrees
  // with it and it differs from the current output.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    hist_d = hist_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_w) begin
      for (int i = 0; i < WIDTH; i++) begin
        hist_d[i] = {hist_q[i][N-2:0], sync_last[i]};
        if ((&hist_d[i]) && !out_q[i]) begin
          out_d[i]  = 1'b1;
          rise_d[i] = 1'b1;
        end else if (!(|hist_d[i]) && out_q[i]) begin
          out_d[i]  = 1'b0;
          fall_d[i] = 1'b1;
        end
      end
    end
  end

  // History, debounced level and edge pulse registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      // NOTE: the history is a small flop array, not a RAM, so it is cleared
      // on reset; stale samples must never vote for a level after reset.
      for (int i = 0; i < WIDTH; i++) begin
        hist_q[i] <= '0;
      end
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      hist_q <= hist_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db.out  = out_q;
  assign db.rise = rise_q;
  assign db.fall = fall_q;
  assign db.tick = tick_w;

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- WIDTH, 13, number of input channels (btnu, btnl, btnd, btnr, btnc, sw[7:0]).
- SYNC_STAGES, 3, synchronizer flops per channel; legal range 2..4.
- RATE, 125000, clock cycles per sample tick; legal range 2..2^20.
- N, 4, consecutive agreeing samples needed to accept a new level; legal range 2..8.

REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock for all logic.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- in, input, WIDTH, raw asynchronous button and switch levels.
- out, output, WIDTH, debounced levels, feeding the fpga_core btn and sw inputs.
- rise, output, WIDTH, one-cycle pulse when out[i] goes 0->1.
- fall, output, WIDTH, one-cycle pulse when out[i] goes 1->0.
- tick, output, 1, one-cycle sample strobe, for observation.

Function
REQ-003 Each in[i] SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync[i]) SHALL be used downstream.
REQ-004 The prescaler SHALL be a counter from 0 to RATE-1 that wraps to 0; tick SHALL be 1 exactly in the cycle the counter equals RATE-1, giving one tick per RATE cycles.
REQ-005 On each tick, each channel SHALL shift sync[i] into an N-bit history register hist[i], newest bit at LSB.
REQ-006 On a tick, out[i] SHALL be updated to b if hist[i] would become all-b (including the sample taken this tick) and b != out[i]; otherwise out[i] SHALL hold.
REQ-007 out SHALL change only in cycles where tick=1, registered, with one cycle of latency from that tick.
REQ-008 rise[i] SHALL be 1 for exactly one cycle, the cycle out[i] first shows 1 after being 0; fall[i] SHALL behave the same for 1->0; rise[i] and fall[i] SHALL never both be 1.
REQ-009 A bouncing input with any disagreeing sample within the last N ticks SHALL leave out[i] unchanged and SHALL generate no pulses.
REQ-010 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous, independent pulses.
REQ-011 Worst-case acceptance latency from a clean edge on in[i] to the out[i] change SHALL be at most SYNC_STAGES + N*RATE + 1 cycles.
REQ-012 Minimum acceptance latency SHALL be at least (N-1)*RATE cycles, so pulses shorter than that are always rejected.

Reset
REQ-013 While rst_n=0, all of the following SHALL be 0, asynchronously: synchronizer flops, hist, prescaler, out, rise, fall, tick.
REQ-014 Reset release SHALL be synchronous to clk through a 2-flop reset synchronizer inside the block.
REQ-015 The first tick after reset release SHALL occur RATE cycles after internal reset deassertion.
REQ-016 Reset asserted mid-count or mid-debounce SHALL discard all history, with no pulse emitted at or after assertion.
REQ-017 An input held at 1 through reset SHALL produce out[i]=1 and a single rise[i] after N ticks.

Verification
REQ-018 The bench SHALL cover the following directed scenarios with RATE=4, N=4, SYNC_STAGES=3:
- Reset with in=0 -> out=0, rise=0, fall=0; tick every 4 cycles after the reset-synchronizer delay.
- in[0] steps 0->1 and holds -> out[0]=1 within 3+16+1 cycles and not before 12 cycles; exactly one rise[0] pulse; no fall.
- in[4] toggles every 5 cycles for 100 cycles -> out[4] stays 0; no pulses.
- in[12:5]=8'hA5 applied together, then 8'h00 -> out[12:5]=8'hA5 with 4 simultaneous rise pulses, then 4 simultaneous fall pulses.
- rst_n pulsed low for 1 cycle while in[1]=1 has 3 of 4 agreeing samples -> out[1]=0 immediately; a rise only after 4 fresh ticks.
- in[2] glitches 1 cycle low during a steady 1 -> out[2] stays 1; no fall[2].
